// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  localparam int MULT_WIDTH_DEF = 32;

  // One spare bit above log2 so the counter can never wrap before the compare.
  function automatic int mult_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the CALC phase: synchronous clear, increment, and a
// terminal flag when the count reaches WIDTH-1. Registered, no backpressure.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF,
  parameter int CNT_W = mult_cnt_w(WIDTH)
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Shift-add multiplier sequencer: result valid WIDTH+1 edges after the request handshake
// (fewer with MULT_EARLY_EXIT_EN); result is held under out_ready backpressure and requests are refused while busy.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               b_is_zero,
  input  logic [2*WIDTH-1:0] prod_in,
  output logic               a_sel,
  output logic               b_sel,
  output logic               prod_sel,
  output logic               shift_en,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  mult_state_t        state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               cnt_term;
  logic               calc_done;

  mult_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (state_q == IDLE),
    .inc   (state_q == CALC),
    .term  (cnt_term)
  );

`ifdef MULT_EARLY_EXIT_EN
  // Once B has shifted out to zero the remaining iterations would only add zero.
  assign calc_done = cnt_term | b_is_zero;
`else
  logic unused_b_is_zero;
  assign unused_b_is_zero = b_is_zero;
  assign calc_done        = cnt_term;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (calc_done) state_d = CAPT;
      CAPT: begin
        result_d    = prod_in;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle keeps the datapath loading operands and clearing the product.
  always_comb begin
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    prod_sel = 1'b0;
    shift_en = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        a_sel    = 1'b1;
        b_sel    = 1'b1;
        prod_sel = 1'b1;
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      CALC:    shift_en = 1'b1;
      default: ;
    endcase
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control with a shift-add datapath model and a timeline scoreboard.
module tb_mult_control;

  localparam int W = 32;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready, b_is_zero, a_sel, b_sel, prod_sel, shift_en, busy, out_valid;
  logic [2*W-1:0]  prod_in, result;
  logic [W-1:0]    op_a = '0;
  logic [W-1:0]    op_b = '0;
  logic [2*W-1:0]  dp_a, dp_p;
  logic [W-1:0]    dp_b;

  typedef struct {
    logic [63:0] prod;
    int          n;
    int          h;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  logic [63:0] res_model = '0;
  int          prev_h = -1000;
  int          last_n = 0;
  int          gap = 0;
  int          gap_n = 0;
  bit          new_hs = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          b2b_mode = 1'b0;
  bit          timed_out = 1'b0;
  int          ordy_mode = 1;

  mult_control #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b_is_zero (b_is_zero),
    .prod_in   (prod_in),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .prod_sel  (prod_sel),
    .shift_en  (shift_en),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 Clock = ~Clock;

  // Datapath the controller sequences.
  initial forever begin
    @(posedge Clock);
    if (Reset) begin
      dp_a <= '0;
      dp_b <= '0;
      dp_p <= '0;
    end else begin
      if (a_sel) dp_a <= {{W{1'b0}}, op_a};
      else if (shift_en) dp_a <= dp_a << 1;
      if (b_sel) dp_b <= op_b;
      else if (shift_en) dp_b <= dp_b >> 1;
      if (prod_sel) dp_p <= '0;
      else if (shift_en) dp_p <= dp_p + (dp_b[0] ? dp_a : '0);
    end
  end
  assign b_is_zero = ~|dp_b;
  assign prod_in   = dp_p;

  // Number of CALC cycles expected for a given B operand.
  function automatic int exp_n(input logic [W-1:0] b);
    int msb;
    msb = 0;
`ifdef MULT_EARLY_EXIT_EN
    if (b == '0) return 1;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    return (msb + 2 > W) ? W : msb + 2;
`else
    msb = int'(b[0]);
    return W + msb - msb;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference timeline: request accepted, product captured, result consumed.
  initial forever begin
    exp_t e;
    @(posedge Clock);
    cyc++;
    new_hs = 1'b0;
    if (Reset) begin
      sb.delete();
      res_model = '0;
    end else if (sb.size() != 0) begin
      if (cyc == sb[0].h + sb[0].n + 1) res_model = sb[0].prod;
      if (out_ready && cyc >= sb[0].h + sb[0].n + 2) void'(sb.pop_front());
    end else if (in_valid) begin
      e.prod = 64'(op_a) * 64'(op_b);
      e.n    = exp_n(op_b);
      e.h    = cyc;
      sb.push_back(e);
      gap    = cyc - prev_h;
      gap_n  = last_n;
      new_hs = 1'b1;
      prev_h = cyc;
      last_n = e.n;
    end
  end

  initial forever begin
    @(negedge Clock);
    case (ordy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every DUT output with the timeline each cycle.
  initial forever begin
    bit pend;
    int k;
    bit exp_sh, exp_ov;
    @(negedge Clock);
    if (mon_en) begin
      pend   = (sb.size() != 0);
      exp_sh = 1'b0;
      exp_ov = 1'b0;
      if (pend) begin
        k      = cyc - sb[0].h;
        exp_sh = (k < sb[0].n);
        exp_ov = (k >= sb[0].n + 1);
      end
      chk("in_ready",  64'(in_ready),  64'(!pend));
      chk("busy",      64'(busy),      64'(pend));
      chk("a_sel",     64'(a_sel),     64'(!pend));
      chk("b_sel",     64'(b_sel),     64'(!pend));
      chk("prod_sel",  64'(prod_sel),  64'(!pend));
      chk("shift_en",  64'(shift_en),  64'(exp_sh));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("result",    result,         res_model);
      chk("timeout",   64'(timed_out), 64'(0));
      if (new_hs && b2b_mode) chk("b2b_period", 64'(gap), 64'(gap_n + 3));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 500) begin
      @(negedge Clock);
      t++;
    end
    if (!in_ready) begin
      timed_out = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge Clock);
    @(negedge Clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge Clock);
      t++;
    end
    if (sb.size() != 0) timed_out = 1'b1;
    repeat (2) @(negedge Clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [W-1:0] a, b;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    mon_en = 1'b1;
    @(negedge Clock);

    issue(32'd3, 32'd5);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    issue(32'h1234, 32'd0);
    wait_idle();
    issue(32'hABCD, 32'd1);
    wait_idle();

    // Backpressure in DONE with ignored requests.
    ordy_mode = 0;
    issue(32'd100, 32'd200);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge Clock);
      t++;
    end
    if (!out_valid) timed_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      op_a = $urandom;
      op_b = $urandom;
      @(negedge Clock);
    end
    in_valid = 1'b0;
    ordy_mode = 1;
    wait_idle();

    // Reset with the counter at 10.
    issue(32'h1111, 32'h8000_0001);
    repeat (10) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    issue(32'd7, 32'd9);
    wait_idle();

    // Back-to-back requests with out_ready high.
    issue(32'd2, 32'd2);
    @(negedge Clock);
    b2b_mode = 1'b1;
    issue(32'd6, 32'd7);
    @(negedge Clock);
    b2b_mode = 1'b0;
    wait_idle();

    // Random operands with random downstream stalls.
    ordy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue(a, b);
    end
    ordy_mode = 1;
    wait_idle();

    @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_control.md
# mult_control

Sequencing controller for the shift-add multiplier datapath. Accepts an operand-pair request through a valid/ready handshake and drives the datapath's `a_sel`, `b_sel`, `prod_sel` and `Shift_Enable` inputs through load and iterate phases. Captures the finished 2·WIDTH product into a result register and presents it downstream with a valid/ready handshake. The datapath shares `Clock` and `Reset`; its operand inputs come straight from the requester.

## Interface
- `WIDTH`, default 32: operand width; the product is 2·WIDTH bits.
- `Clock`, in, 1: clock; all state changes on the rising edge.
- `Reset`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: requester has operands on the datapath inputs.
- `in_ready`, out, 1: controller can accept a request; high only in IDLE.
- `b_is_zero`, in, 1: reduce-NOR of the datapath B register. Used only when `MULT_EARLY_EXIT_EN` is defined; otherwise ignored.
- `prod_in`, in, 2·WIDTH: datapath product register.
- `a_sel`, out, 1: 1 = load operand A; 0 = take shifted A.
- `b_sel`, out, 1: 1 = load operand B; 0 = take shifted B.
- `prod_sel`, out, 1: 1 = clear product; 0 = take conditional sum.
- `shift_en`, out, 1: shift enable to the datapath.
- `busy`, out, 1: high in CALC, CAPT and DONE.
- `out_valid`, out, 1: `result` holds a finished product.
- `out_ready`, in, 1: downstream accepts the result.
- `result`, out, 2·WIDTH: registered product.

## Operation
- States: IDLE, CALC, CAPT, DONE. Reset state is IDLE.
- **IDLE**
  - Outputs: `a_sel`, `b_sel` and `prod_sel` = 1; `shift_en` = 0; `in_ready` = 1. The datapath therefore loads its operands and clears the product on every edge.
  - On `in_valid` and `in_ready`: go to CALC; iteration counter ← 0.
- **CALC**
  - Outputs: all selects = 0; `shift_en` = 1.
  - The counter increments each cycle.
  - Exit to CAPT when counter == WIDTH−1. With `MULT_EARLY_EXIT_EN`, also exit when `b_is_zero` = 1.
- **CAPT**
  - Outputs: selects = 0; `shift_en` = 0.
  - `result` ← `prod_in`; `out_valid` ← 1; go to DONE.
- **DONE**
  - Outputs: selects = 0; `shift_en` = 0.
  - `result` and `out_valid` are held until `out_valid` and `out_ready`. Then `out_valid` ← 0 and go to IDLE.
  - The product register is stable here because B has shifted to zero.
- The counter is ⌈log2(WIDTH)⌉+1 bits wide and never wraps. It is cleared on entry to CALC.
- `in_valid` outside IDLE is ignored and the request is not queued. The requester must hold its operands until `in_ready` is sampled high.
- A reset during any state returns the block to IDLE immediately. It clears `out_valid`, `result` and the counter, and discards any in-flight product.

## Timing
- Reset values:
  - `in_ready` = 1, `busy` = 0, `out_valid` = 0, `result` = 0.
  - `a_sel`, `b_sel`, `prod_sel` = 1; `shift_en` = 0.
- Edge numbering: handshake at edge E0.
  - CALC lasts cycles E0..E(N−1), where N is the number of CALC cycles.
  - CAPT lasts one cycle.
  - `out_valid` rises after edge E(N+1).
- Default latency: N = WIDTH, so `out_valid` is high WIDTH+1 edges after the handshake.
- Back-to-back throughput: the earliest next `in_ready` is the cycle after the DONE handshake edge. The minimum period is WIDTH+3 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- `MULT_EARLY_EXIT_EN`
  - Defined: CALC ends at the first cycle with `b_is_zero` = 1, or at counter == WIDTH−1, whichever comes first. For B = 0, N = 1. For B = 1, N = 2. For B with its MSB set, N = WIDTH.
  - Undefined: `b_is_zero` is unused and N = WIDTH always.
  - The product value is identical in both builds.

## Structure
- Package `mult_pkg`:
  - state enum `mult_state_t` (IDLE, CALC, CAPT, DONE);
  - `MULT_WIDTH_DEF` = 32;
  - counter-width function `mult_cnt_w(WIDTH)`.
- Sub-module `mult_iter_counter`: clear, increment and terminal-compare (== WIDTH−1).
- The FSM and the result register live in `mult_control`.

## Test plan
- **Basic multiply.** A = 3, B = 5, WIDTH = 32 with the datapath attached → `result` = 64'h0F; `out_valid` 33 edges after the handshake; `in_ready` low throughout.
- **Full-scale multiply.** A = B = 32'hFFFFFFFF → `result` = 64'hFFFFFFFE00000001.
- **Backpressure.** Hold `out_ready` = 0 for 10 cycles in DONE → `result` and `out_valid` stable, and `in_valid` pulses are ignored; release → IDLE next cycle.
- **Reset mid-operation.** Assert `Reset` at CALC counter = 10 → next cycle: IDLE, `out_valid` = 0, `result` = 0. A new request 7×9 then yields 63.
- **Early exit (macro defined).**
  - B = 0 → `result` = 0; `out_valid` 2 edges after the handshake.
  - B = 1, A = 0xABCD → `result` = 0xABCD; `out_valid` 3 edges after the handshake.
- **Back-to-back.** `out_ready` tied high with requests queued → successive results 2×2 = 4, then 6×7 = 42; period = WIDTH+3 cycles.
